// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    // One register-file write: enable, destination, data.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } rfWrite_t;

    typedef enum logic {
        NORMAL,
        STARVE
    } starveState_t;

    function automatic logic [NUM_REGS-1:0] oneHot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between Writeback/late source, the arbiter and the register file.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  RegWriteW;
    logic [REG_ADDR_W-1:0] RdW;
    logic [XLEN-1:0]       ResultW;
    logic                  LateValid;
    logic [REG_ADDR_W-1:0] LateRd;
    logic [XLEN-1:0]       LateData;
    logic                  LateReady;
    logic                  RegWriteRF;
    logic [REG_ADDR_W-1:0] RdRF;
    logic [XLEN-1:0]       WDataRF;
    logic [NUM_REGS-1:0]   PendingMask;
    logic                  StallWB;

    // Arbiter side.
    modport slave (
        input  RegWriteW, RdW, ResultW, LateValid, LateRd, LateData,
        output LateReady, RegWriteRF, RdRF, WDataRF, PendingMask, StallWB
    );

    // Environment side (pipeline, late unit, register file, hazard unit).
    modport master (
        output RegWriteW, RdW, ResultW, LateValid, LateRd, LateData,
        input  LateReady, RegWriteRF, RdRF, WDataRF, PendingMask, StallWB
    );

endinterface

// File: rtl/wb_port_arbiter_late_fifo.sv
// Small FIFO holding late results that could not reach the write port.
module late_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [REG_ADDR_W-1:0]             pushRd,
    input  logic [XLEN-1:0]                   pushData,
    input  logic                              pop,
    output logic [REG_ADDR_W-1:0]             headRd,
    output logic [XLEN-1:0]                   headData,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic [DEPTH-1:0]                  entryValid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]  entryRd
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]                     wrPtr;
    logic [PW-1:0]                     rdPtr;
    logic [DEPTH-1:0]                  validQ;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  memRd;
    logic [XLEN-1:0]                   memData [DEPTH];

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign headRd     = memRd[rdPtr];
    assign headData   = memData[rdPtr];
    assign entryValid = validQ;
    assign entryRd    = memRd;

    // Pointers, occupancy and per-slot valid bits.
    // Push only targets a free slot and pop only a filled one, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            validQ <= '0;
        end else begin
            if (push) begin
                wrPtr         <= wrPtr + PW'(1);
                validQ[wrPtr] <= 1'b1;
            end
            if (pop) begin
                rdPtr         <= rdPtr + PW'(1);
                validQ[rdPtr] <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents of invalid slots are don't-care.
    always_ff @(posedge clk) begin
        if (push) begin
            memRd[wrPtr]   <= pushRd;
            memData[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline first, buffered late results next,
// same-cycle bypass for late results when nothing is queued.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic                             pipeActive;
    logic                             lateXfer;
    logic                             lateUseful;
    logic                             push;
    logic                             pop;
    logic                             bypass;
    logic [REG_ADDR_W-1:0]            headRd;
    logic [XLEN-1:0]                  headData;
    logic                             full;
    logic                             empty;
    logic [CW-1:0]                    count;
    logic [CW-1:0]                    countNext;
    logic [DEPTH-1:0]                 entryValid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entryRd;
    rfWrite_t                         wr;
    logic [NUM_REGS-1:0]              mask;
    starveState_t                     state;
    logic [3:0]                       waitCnt;
    logic [3:0]                       waitInc;
    logic                             stallQ;

    late_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pushRd     (bus.LateRd),
        .pushData   (bus.LateData),
        .pop        (pop),
        .headRd     (headRd),
        .headData   (headData),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .entryValid (entryValid),
        .entryRd    (entryRd)
    );

    // Handshake and port-selection decisions.
    always_comb begin
        pipeActive = bus.RegWriteW && (bus.RdW != '0);
        lateXfer   = bus.LateValid && !full;
        lateUseful = lateXfer && (bus.LateRd != '0);
        pop        = !pipeActive && !empty;
        bypass     = !pipeActive && empty && lateUseful;
        push       = lateUseful && !bypass;
        countNext  = count + CW'(push) - CW'(pop);
        waitInc    = waitCnt + 4'd1;
    end

    // Write-port mux in priority order: pipeline, FIFO head, bypass, idle.
    always_comb begin
        wr = '0;
        if (pipeActive) begin
            wr.we   = 1'b1;
            wr.rd   = bus.RdW;
            wr.data = bus.ResultW;
        end else if (!empty) begin
            wr.we   = 1'b1;
            wr.rd   = headRd;
            wr.data = headData;
        end else if (bypass) begin
            wr.we   = 1'b1;
            wr.rd   = bus.LateRd;
            wr.data = bus.LateData;
        end
    end

    // Destinations with a queued write, for the hazard unit.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) begin
                mask = mask | oneHot(entryRd[i]);
            end
        end
    end

    // Starvation FSM: count blocked cycles, request a bubble until the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= NORMAL;
            waitCnt <= '0;
            stallQ  <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (empty || pop) begin
                        waitCnt <= '0;
                    end else if (pipeActive) begin
                        if (waitInc == 4'(MAX_WAIT)) begin
                            state   <= STARVE;
                            waitCnt <= '0;
                            stallQ  <= 1'b1;
                        end else begin
                            waitCnt <= waitInc;
                        end
                    end
                end
                STARVE: begin
                    waitCnt <= '0;
                    if (countNext == '0) begin
                        state  <= NORMAL;
                        stallQ <= 1'b0;
                    end
                end
                default: begin
                    state   <= NORMAL;
                    waitCnt <= '0;
                    stallQ  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LateReady   = !full;
    assign bus.RegWriteRF  = wr.we;
    assign bus.RdRF        = wr.rd;
    assign bus.WDataRF     = wr.data;
    assign bus.PendingMask = mask;
    assign bus.StallWB     = stallQ;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_wb_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        regWrite;
        logic [4:0]  rdW;
        logic [31:0] resultW;
        logic        lateValid;
        logic [4:0]  lateRd;
        logic [31:0] lateData;
        logic        expReady;
        logic        expWe;
        logic [4:0]  expRd;
        logic [31:0] expData;
        logic [31:0] expMask;
        logic        expStall;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        bus.RegWriteW = rw;
        bus.RdW       = rd;
        bus.ResultW   = res;
        bus.LateValid = lv;
        bus.LateRd    = lrd;
        bus.LateData  = ld;
    endtask

    task automatic checkOutputs(input int idx, input logic eR, input logic eWe, input logic [4:0] eRd,
                                input logic [31:0] eData, input logic [31:0] eMask, input logic eStall);
        checkEq($sformatf("v%0d.LateReady", idx),   32'(bus.LateReady),  32'(eR));
        checkEq($sformatf("v%0d.RegWriteRF", idx),  32'(bus.RegWriteRF), 32'(eWe));
        checkEq($sformatf("v%0d.RdRF", idx),        32'(bus.RdRF),       32'(eRd));
        checkEq($sformatf("v%0d.WDataRF", idx),     bus.WDataRF,         eData);
        checkEq($sformatf("v%0d.PendingMask", idx), bus.PendingMask,     eMask);
        checkEq($sformatf("v%0d.StallWB", idx),     32'(bus.StallWB),    32'(eStall));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            rw  rdW  resW        lv  lRd  lData        rdy we rd  data         mask         stall
        // reset idle
        vecs[0]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,       32'h0,       0};
        // bypass x5
        vecs[1]  = '{0, 5'd0, 32'h0,       1, 5'd5,  32'hDEAD,    1, 1, 5'd5,  32'hDEAD,    32'h0,       0};
        // collision x3 pipe / x7 late, then x7 drains, mask bit7 one cycle
        vecs[2]  = '{1, 5'd3, 32'h11,      1, 5'd7,  32'h22,      1, 1, 5'd3,  32'h11,      32'h0,       0};
        vecs[3]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 1, 5'd7,  32'h22,      32'h80,      0};
        vecs[4]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,       32'h0,       0};
        // x0 handling: pipe rd0 ignored, late x9 bypasses; late rd0 discarded
        vecs[5]  = '{1, 5'd0, 32'h55,      1, 5'd9,  32'h99,      1, 1, 5'd9,  32'h99,      32'h0,       0};
        vecs[6]  = '{0, 5'd0, 32'h0,       1, 5'd0,  32'h77,      1, 0, 5'd0,  32'h0,       32'h0,       0};
        vecs[7]  = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,       32'h0,       0};
        // full: pipe busy, two late results fill FIFO, third held
        vecs[8]  = '{1, 5'd1, 32'hA1,      1, 5'd10, 32'hB0,      1, 1, 5'd1,  32'hA1,      32'h0,       0};
        vecs[9]  = '{1, 5'd2, 32'hA2,      1, 5'd11, 32'hB1,      1, 1, 5'd2,  32'hA2,      32'h400,     0};
        vecs[10] = '{1, 5'd4, 32'hA4,      1, 5'd12, 32'hC2,      0, 1, 5'd4,  32'hA4,      32'hC00,     0};
        vecs[11] = '{0, 5'd0, 32'h0,       1, 5'd12, 32'hC2,      0, 1, 5'd10, 32'hB0,      32'hC00,     0};
        vecs[12] = '{0, 5'd0, 32'h0,       1, 5'd12, 32'hC2,      1, 1, 5'd11, 32'hB1,      32'h800,     0};
        vecs[13] = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 1, 5'd12, 32'hC2,      32'h1000,    0};
        vecs[14] = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,       32'h0,       0};
        // starvation: one entry, pipeline active 4 cycles, stall on 5th, bubble drains
        vecs[15] = '{1, 5'd1, 32'h1,       1, 5'd13, 32'hD0,      1, 1, 5'd1,  32'h1,       32'h0,       0};
        vecs[16] = '{1, 5'd2, 32'h2,       0, 5'd0,  32'h0,       1, 1, 5'd2,  32'h2,       32'h2000,    0};
        vecs[17] = '{1, 5'd3, 32'h3,       0, 5'd0,  32'h0,       1, 1, 5'd3,  32'h3,       32'h2000,    0};
        vecs[18] = '{1, 5'd4, 32'h4,       0, 5'd0,  32'h0,       1, 1, 5'd4,  32'h4,       32'h2000,    0};
        vecs[19] = '{1, 5'd5, 32'h5,       0, 5'd0,  32'h0,       1, 1, 5'd5,  32'h5,       32'h2000,    0};
        vecs[20] = '{1, 5'd6, 32'h6,       0, 5'd0,  32'h0,       1, 1, 5'd6,  32'h6,       32'h2000,    1};
        vecs[21] = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 1, 5'd13, 32'hD0,      32'h2000,    1};
        vecs[22] = '{0, 5'd0, 32'h0,       0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,       32'h0,       0};

        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].regWrite, vecs[i].rdW, vecs[i].resultW,
                  vecs[i].lateValid, vecs[i].lateRd, vecs[i].lateData);
            #3;
            checkOutputs(i, vecs[i].expReady, vecs[i].expWe, vecs[i].expRd,
                         vecs[i].expData, vecs[i].expMask, vecs[i].expStall);
            @(posedge clk);
            #1;
        end

        // Reset mid-traffic: fill FIFO and reach STARVE, then pulse async reset.
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(i + 1), 32'(i), 1, 5'(20 + i), 32'(32'h100 + i));
            @(posedge clk);
            #1;
        end
        drive(1, 5'd6, 32'h6, 1, 5'd25, 32'h105);
        #2;
        checkEq("pre_rst.StallWB", 32'(bus.StallWB), 32'd1);
        checkEq("pre_rst.LateReady", 32'(bus.LateReady), 32'd0);
        checkEq("pre_rst.PendingMask", bus.PendingMask, 32'h0030_0000);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        checkEq("rst.LateReady", 32'(bus.LateReady), 32'd1);
        checkEq("rst.PendingMask", bus.PendingMask, 32'h0);
        checkEq("rst.StallWB", 32'(bus.StallWB), 32'd0);
        checkEq("rst.RegWriteRF", 32'(bus.RegWriteRF), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        checkEq("post_rst.RegWriteRF", 32'(bus.RegWriteRF), 32'd0);
        @(posedge clk);
        #1;
        // Empty after reset, so a late result must bypass.
        drive(0, 5'd0, 32'h0, 1, 5'd5, 32'hBEEF);
        #3;
        checkEq("post_rst.bypassWe", 32'(bus.RegWriteRF), 32'd1);
        checkEq("post_rst.bypassRd", 32'(bus.RdRF), 32'd5);
        checkEq("post_rst.bypassData", bus.WDataRF, 32'hBEEF);
        checkEq("post_rst.bypassMask", bus.PendingMask, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #3;
        checkEq("post_bypass.RegWriteRF", 32'(bus.RegWriteRF), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline Writeback stage and a late-result source (multi-cycle MUL/DIV unit, load-return path). Pipeline writes always win; late results are written when the port is free, else held in a small FIFO. A starvation FSM requests a writeback bubble when late results have waited too long. Sits between the writeback result mux / late unit and the register file write port.

## Interface
- DEPTH, 2, late-result FIFO entries (power of 2, ≥2)
- MAX_WAIT, 4, consecutive blocked cycles before starvation stall (1–15)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- RegWriteW  in  1  pipeline write enable (Writeback stage)
- RdW  in  5  pipeline destination register
- ResultW  in  32  pipeline write data (writeback mux output)
- LateValid  in  1  late source offers a result
- LateRd  in  5  late destination register
- LateData  in  32  late write data
- LateReady  out  1  arbiter accepts the late result this cycle
- RegWriteRF  out  1  register-file write enable
- RdRF  out  5  register-file write address
- WDataRF  out  32  register-file write data
- PendingMask  out  32  bit r set while a FIFO entry targets register r (for hazard unit)
- StallWB  out  1  request: hazard unit inserts a Writeback bubble next cycle

## Operation
- Late handshake: transfer when LateValid && LateReady. LateReady = !full (combinational from FIFO state only, never from LateValid).
- Pipeline write "active" = RegWriteW && RdW != 0. RegWriteW with RdW == 0 is ignored (port counts as free).
- Port selection each cycle, priority order:
  1. pipeline active → write RdW/ResultW.
  2. FIFO non-empty → write head entry, pop.
  3. late transfer with FIFO empty → bypass: write LateRd/LateData same cycle, not enqueued.
  4. none → RegWriteRF=0, RdRF=0, WDataRF=0.
- Late transfer not bypassed is enqueued; enqueue and pop in the same cycle allowed (count unchanged). Late entries with LateRd == 0 are accepted and discarded (not enqueued, not written).
- PendingMask: OR of one-hot(rd) over valid FIFO entries; registered view of FIFO contents (does not include a same-cycle bypass).
- Ordering between a pipeline write and a pending late write to the same rd is not resolved here; the hazard unit uses PendingMask to stall.
- Starvation FSM, states NORMAL, STARVE:
  - wait counter (4 bits) increments each cycle FIFO non-empty and pipeline active; clears when FIFO empty or a pop occurs.
  - NORMAL→STARVE when counter reaches MAX_WAIT.
  - STARVE: StallWB=1; counter held at 0; →NORMAL on cycle FIFO becomes empty (count 0 after update).
  - StallWB is a request only; if RegWriteW stays active in STARVE, pipeline still wins.

## Timing
- Reset (async): FIFO empty, pointers 0, counter 0, state NORMAL. Outputs: LateReady=1, StallWB=0, PendingMask=0, RegWriteRF/RdRF/WDataRF follow inputs combinationally (0 with all inputs idle). Reset mid-operation discards all buffered late results.
- Write path: combinational, zero latency; register file captures on its own edge.
- Enqueued entry earliest write: next cycle. FIFO order strictly FIFO.
- Full: LateReady=0; a pop in the same cycle does not raise LateReady until the next cycle.
- StallWB asserts the cycle after the counter reaches MAX_WAIT (registered state).

## Structure
- Shared package: rf-write record (we, rd[4:0], data[31:0]), XLEN=32, REG_ADDR_W=5.
- Sub-module: late_fifo (DEPTH, synchronous push/pop, full/empty/count, entry-valid vector for PendingMask).
- Arbiter mux, starvation FSM, mask decode in top.

## Test plan
- Reset idle: rst pulse mid-traffic → FIFO empty, LateReady=1, PendingMask=0, StallWB=0.
- Bypass: FIFO empty, RegWriteW=0, LateValid x5=0xDEAD → RegWriteRF=1, RdRF=5, WDataRF=0xDEAD same cycle, PendingMask=0.
- Collision: RegWriteW x3=0x11 and late x7=0x22 same cycle → x3 written; next cycle (no pipeline write) x7=0x22 written; PendingMask bit7 high exactly one cycle.
- Full: pipeline active continuously, two late results → LateReady=0 after second; third LateValid held until a slot frees.
- Starvation (MAX_WAIT=4): FIFO holds one entry, pipeline active 4 cycles → StallWB=1 on cycle 5; bubble → entry drained, StallWB=0 next cycle.
- x0 handling: RegWriteW rd=0 and late x9 → x9 bypass-written; late rd=0 → accepted, never written.
